// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz VGA timing constants and the coordinate width used by
// vga_sync_controller and pixel_generation.
package vga_timing_pkg;

   localparam int HD = 640;
   localparam int HF = 16;
   localparam int HR = 96;
   localparam int HB = 48;
   localparam int VD = 480;
   localparam int VF = 10;
   localparam int VR = 2;
   localparam int VB = 33;

   localparam int H_TOTAL = HD + HF + HR + HB;
   localparam int V_TOTAL = VD + VF + VR + VB;

   localparam int COORD_W = 10;

   localparam int CLK_DIV = 4;

   // A divide-by-one still needs a one-bit counter to stay legal.
   function automatic int div_width(input int div);
      int w;
      w = $clog2(div);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock by CLK_DIV into a combinational counter enable
// (tick_en) and its registered, one-cycle-later copy (p_tick).
module pixel_tick_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV = vga_timing_pkg::CLK_DIV
) (
   input  logic clk,
   input  logic reset,
   output logic tick_en,
   output logic p_tick
);

   localparam int DW = div_width(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_ONE  = DW'(1);

   logic [DW-1:0] div_q, div_d;
   logic          p_tick_q, p_tick_d;
   logic          tick_en_s;

   always_comb begin
      tick_en_s = (div_q == DIV_LAST);
      if (tick_en_s) begin
         div_d = '0;
      end else begin
         div_d = div_q + DIV_ONE;
      end
      p_tick_d = tick_en_s;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q    <= '0;
         p_tick_q <= 1'b0;
      end else begin
         div_q    <= div_d;
         p_tick_q <= p_tick_d;
      end
   end

   assign tick_en = tick_en_s;
   assign p_tick  = p_tick_q;

endmodule

// File: rtl/vga_sync_controller.sv
// VGA scan counters and sync generation. Define VGA_SYNC_FRAME_TICK_EN to add
// the frame_tick output pulsing on the tick where the counts wrap to (0,0).
module vga_sync_controller
   import vga_timing_pkg::*;
#(
   parameter int HD      = vga_timing_pkg::HD,
   parameter int HF      = vga_timing_pkg::HF,
   parameter int HR      = vga_timing_pkg::HR,
   parameter int HB      = vga_timing_pkg::HB,
   parameter int VD      = vga_timing_pkg::VD,
   parameter int VF      = vga_timing_pkg::VF,
   parameter int VR      = vga_timing_pkg::VR,
   parameter int VB      = vga_timing_pkg::VB,
   parameter int CLK_DIV = vga_timing_pkg::CLK_DIV
) (
   input  logic               clk_100MHz,
   input  logic               reset,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic               p_tick,
`ifdef VGA_SYNC_FRAME_TICK_EN
   output logic               frame_tick,
`endif
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y
);

   localparam int HT = HD + HF + HR + HB;
   localparam int VT = VD + VF + VR + VB;

   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(HT - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(VT - 1);
   localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(HD);
   localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(VD);
   localparam logic [COORD_W-1:0] HS_START = COORD_W'(HD + HF);
   localparam logic [COORD_W-1:0] HS_END   = COORD_W'(HD + HF + HR - 1);
   localparam logic [COORD_W-1:0] VS_START = COORD_W'(VD + VF);
   localparam logic [COORD_W-1:0] VS_END   = COORD_W'(VD + VF + VR - 1);
   localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

   logic                tick_en_s;
   logic                p_tick_s;
   logic [COORD_W-1:0]  h_count_q, h_count_d;
   logic [COORD_W-1:0]  v_count_q, v_count_d;
   logic                hsync_q, hsync_d;
   logic                vsync_q, vsync_d;
   logic                frame_tick_q, frame_tick_d;

   pixel_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_pixel_tick_gen (
      .clk     (clk_100MHz),
      .reset   (reset),
      .tick_en (tick_en_s),
      .p_tick  (p_tick_s)
   );

   // Syncs are decoded from the next counts so they land on the same edge as x/y.
   always_comb begin
      h_count_d    = h_count_q;
      v_count_d    = v_count_q;
      frame_tick_d = 1'b0;
      if (tick_en_s) begin
         if (h_count_q == H_LAST) begin
            h_count_d = '0;
            if (v_count_q == V_LAST) begin
               v_count_d    = '0;
               frame_tick_d = 1'b1;
            end else begin
               v_count_d = v_count_q + ONE;
            end
         end else begin
            h_count_d = h_count_q + ONE;
         end
      end else begin
         h_count_d = h_count_q;
      end
      hsync_d = !((h_count_d >= HS_START) && (h_count_d <= HS_END));
      vsync_d = !((v_count_d >= VS_START) && (v_count_d <= VS_END));
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         h_count_q    <= '0;
         v_count_q    <= '0;
         hsync_q      <= 1'b1;
         vsync_q      <= 1'b1;
         frame_tick_q <= 1'b0;
      end else begin
         h_count_q    <= h_count_d;
         v_count_q    <= v_count_d;
         hsync_q      <= hsync_d;
         vsync_q      <= vsync_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign hsync    = hsync_q;
   assign vsync    = vsync_q;
   assign video_on = (h_count_q < H_VIS) && (v_count_q < V_VIS);
   assign p_tick   = p_tick_s;
   assign x        = h_count_q;
   assign y        = v_count_q;

`ifdef VGA_SYNC_FRAME_TICK_EN
   assign frame_tick = frame_tick_q;
`else
   logic unused_frame_tick_s;
   assign unused_frame_tick_s = frame_tick_q;
`endif

endmodule

// File: tb/tb_vga_sync_controller.sv
// Randomized-reset bench: a full-size instance runs two-plus lines, and a
// scaled-timing instance runs many whole frames against a cycle-count model.
module tb_vga_sync_controller;

   typedef struct {
      int x;
      int y;
      int hs;
      int vs;
      int von;
      int pt;
      int ft;
   } exp_t;

   logic       clk;
   logic       rst_d, rst_s;
   logic       hs_d, vs_d, von_d, pt_d, ft_d;
   logic       hs_s, vs_s, von_s, pt_s, ft_s;
   logic [9:0] x_d, y_d, x_s, y_s;

   int n_checks = 0;
   int n_errors = 0;
   int t_d = 0;
   int t_s = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vga_sync_controller dut_d (
      .clk_100MHz (clk),
      .reset      (rst_d),
      .hsync      (hs_d),
      .vsync      (vs_d),
      .video_on   (von_d),
      .p_tick     (pt_d),
`ifdef VGA_SYNC_FRAME_TICK_EN
      .frame_tick (ft_d),
`endif
      .x          (x_d),
      .y          (y_d)
   );

   vga_sync_controller #(
      .HD (20), .HF (3), .HR (5), .HB (4),
      .VD (12), .VF (2), .VR (2), .VB (3),
      .CLK_DIV (3)
   ) dut_s (
      .clk_100MHz (clk),
      .reset      (rst_s),
      .hsync      (hs_s),
      .vsync      (vs_s),
      .video_on   (von_s),
      .p_tick     (pt_s),
`ifdef VGA_SYNC_FRAME_TICK_EN
      .frame_tick (ft_s),
`endif
      .x          (x_s),
      .y          (y_s)
   );

`ifndef VGA_SYNC_FRAME_TICK_EN
   assign ft_d = 1'b0;
   assign ft_s = 1'b0;
`endif

   task automatic check(input string tag, input int obs, input int expv);
      n_checks++;
      if (obs != expv) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   // t = clock edges since the last edge that saw reset high.
   function automatic exp_t model(input int t, input int hd, input int hf, input int hr,
                                  input int hb, input int vd, input int vf, input int vr,
                                  input int vb, input int cd);
      exp_t e;
      int ht, vt, pos;
      ht    = hd + hf + hr + hb;
      vt    = vd + vf + vr + vb;
      pos   = (t / cd) % (ht * vt);
      e.x   = pos % ht;
      e.y   = pos / ht;
      e.hs  = (e.x >= hd + hf && e.x < hd + hf + hr) ? 0 : 1;
      e.vs  = (e.y >= vd + vf && e.y < vd + vf + vr) ? 0 : 1;
      e.von = (e.x < hd && e.y < vd) ? 1 : 0;
      e.pt  = (t > 0 && (t % cd) == 0) ? 1 : 0;
      e.ft  = (e.pt == 1 && pos == 0) ? 1 : 0;
      return e;
   endfunction

   task automatic step_d();
      exp_t e;
      @(posedge clk);
      t_d = rst_d ? 0 : t_d + 1;
      @(negedge clk);
      e = model(t_d, 640, 16, 96, 48, 480, 10, 2, 33, 4);
      check("d_x", x_d, e.x);
      check("d_y", y_d, e.y);
      check("d_hsync", hs_d, e.hs);
      check("d_vsync", vs_d, e.vs);
      check("d_video_on", von_d, e.von);
      check("d_p_tick", pt_d, e.pt);
`ifdef VGA_SYNC_FRAME_TICK_EN
      check("d_frame_tick", ft_d, e.ft);
`endif
   endtask

   task automatic step_s();
      exp_t e;
      @(posedge clk);
      t_s = rst_s ? 0 : t_s + 1;
      @(negedge clk);
      e = model(t_s, 20, 3, 5, 4, 12, 2, 2, 3, 3);
      check("s_x", x_s, e.x);
      check("s_y", y_s, e.y);
      check("s_hsync", hs_s, e.hs);
      check("s_vsync", vs_s, e.vs);
      check("s_video_on", von_s, e.von);
      check("s_p_tick", pt_s, e.pt);
`ifdef VGA_SYNC_FRAME_TICK_EN
      check("s_frame_tick", ft_s, e.ft);
`endif
   endtask

   initial begin
      int mid_rst;
      int hold;
      rst_d = 1'b1;
      rst_s = 1'b1;
      repeat (5) step_d();
      rst_d = 1'b0;
      // Full-size timing: a bit over two lines, with one mid-line reset pulse.
      mid_rst = $urandom_range(4000, 5500);
      for (int i = 0; i < 8000; i++) begin
         rst_d = (i == mid_rst) ? 1'b1 : 1'b0;
         step_d();
      end
      rst_d = 1'b0;

      // Scaled timing: many frames, occasional random resets of 1..5 cycles.
      repeat (5) step_s();
      rst_s = 1'b0;
      for (int i = 0; i < 30000; i++) begin
         if (rst_s) begin
            hold--;
            if (hold == 0) rst_s = 1'b0;
         end else if ($urandom_range(0, 2999) == 0) begin
            rst_s = 1'b1;
            hold  = $urandom_range(1, 5);
         end
         step_s();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
